// File: rtl/pwr_seq.sv
// Load-switch power sequencer: soft-start, overcurrent trip, cooldown, optional auto-retry (PWR_SEQ_AUTO_RETRY_EN).
// Latency: one clock from sampled inputs to registered state and outputs; no combinational input-to-output path.
// Backpressure: none; inputs are level-sampled every clock and never stalled.
module pwr_seq #(
    parameter int SS_CYCLES       = 16,
    parameter int OC_LIMIT_MA     = 500,
    parameter int OC_TRIP_CYCLES  = 8,
    parameter int COOLDOWN_CYCLES = 64,
    parameter int MAX_RETRIES     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_on,
    input  logic [11:0] current_ma,
    input  logic        fuse_blown,
    input  logic        powered,
    output logic        pwr_en,
    output logic [2:0]  state,
    output logic        ready,
    output logic        fault,
    output logic [1:0]  retry_cnt
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_SOFT = 3'd1,
        S_ON   = 3'd2,
        S_COOL = 3'd3,
        S_LOCK = 3'd4
    } state_e;

    localparam logic [12:0] INRUSH_LIM = 13'(2 * OC_LIMIT_MA);
    localparam logic [11:0] OC_LIM     = 12'(OC_LIMIT_MA);
    localparam logic [3:0]  TRIP_LIM   = 4'(OC_TRIP_CYCLES);
    localparam logic [7:0]  SS_LAST    = 8'(SS_CYCLES - 1);
    localparam logic [7:0]  CD_LAST    = 8'(COOLDOWN_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  trip_q, trip_d, trip_nxt;
    logic [1:0]  retry_q, retry_d;
    logic        retry_ok;
    logic        pwr_en_q, ready_q, fault_q;

`ifdef PWR_SEQ_AUTO_RETRY_EN
    assign retry_ok = (retry_q < RETRY_MAX) && (retry_q != 2'd3);
`else
    logic unused_retry_cfg;
    assign unused_retry_cfg = ^RETRY_MAX;
    assign retry_ok = 1'b0;
`endif

    // Trip counter saturates so a long overload cannot wrap back under the limit.
    always_comb begin
        trip_nxt = 4'd0;
        if (current_ma > OC_LIM) begin
            trip_nxt = (trip_q == 4'hF) ? trip_q : trip_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        trip_d  = trip_q;
        retry_d = retry_q;
        case (state_q)
            S_OFF: begin
                timer_d = 8'd0;
                trip_d  = 4'd0;
                retry_d = 2'd0;
                if (req_on) begin
                    state_d = S_SOFT;
                end
            end
            S_SOFT, S_ON, S_COOL: begin
                if (fuse_blown) begin
                    state_d = S_LOCK;
                end else if (!req_on) begin
                    state_d = S_OFF;
                    timer_d = 8'd0;
                    trip_d  = 4'd0;
                    retry_d = 2'd0;
                end else if (state_q == S_SOFT) begin
                    if ({1'b0, current_ma} > INRUSH_LIM) begin
                        state_d = S_COOL;
                        timer_d = 8'd0;
                        trip_d  = 4'd0;
                    end else if (timer_q == SS_LAST) begin
                        state_d = powered ? S_ON : S_COOL;
                        timer_d = 8'd0;
                        trip_d  = 4'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end else if (state_q == S_ON) begin
                    trip_d = trip_nxt;
                    if (!powered || (trip_nxt >= TRIP_LIM)) begin
                        state_d = S_COOL;
                        timer_d = 8'd0;
                        trip_d  = 4'd0;
                    end
                end else begin
                    if (timer_q == CD_LAST) begin
                        timer_d = 8'd0;
                        trip_d  = 4'd0;
                        if (retry_ok) begin
                            state_d = S_SOFT;
                            retry_d = retry_q + 2'd1;
                        end else begin
                            state_d = S_LOCK;
                        end
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            S_LOCK: begin
                if (!req_on && !fuse_blown) begin
                    state_d = S_OFF;
                    timer_d = 8'd0;
                    trip_d  = 4'd0;
                    retry_d = 2'd0;
                end
            end
            default: begin
                state_d = S_OFF;
                timer_d = 8'd0;
                trip_d  = 4'd0;
                retry_d = 2'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            timer_q  <= 8'd0;
            trip_q   <= 4'd0;
            retry_q  <= 2'd0;
            pwr_en_q <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            trip_q   <= trip_d;
            retry_q  <= retry_d;
            pwr_en_q <= (state_d == S_SOFT) || (state_d == S_ON);
            ready_q  <= (state_d == S_ON);
            fault_q  <= (state_d == S_COOL) || (state_d == S_LOCK);
        end
    end

    assign state     = state_q;
    assign pwr_en    = pwr_en_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Directed bench for pwr_seq at default parameters; expectations follow PWR_SEQ_AUTO_RETRY_EN when defined.
module tb_pwr_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_on = 1'b0;
    logic [11:0] current_ma = 12'd0;
    logic        fuse_blown = 1'b0;
    logic        powered = 1'b0;
    logic        pwr_en;
    logic [2:0]  state;
    logic        ready;
    logic        fault;
    logic [1:0]  retry_cnt;
    logic [7:0]  obs;
    int          checks = 0;
    int          errors = 0;

    localparam logic [2:0] OFF = 3'd0, SS = 3'd1, ON = 3'd2, CD = 3'd3, LK = 3'd4;

    pwr_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_on     (req_on),
        .current_ma (current_ma),
        .fuse_blown (fuse_blown),
        .powered    (powered),
        .pwr_en     (pwr_en),
        .state      (state),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {state, pwr_en, ready, fault, retry_cnt};

    // Expected observation vector {state, pwr_en, ready, fault, retry_cnt}.
    function automatic logic [7:0] ex(input logic [2:0] s, input logic [1:0] r);
        logic pe, rd, ft;
        pe = (s == SS) || (s == ON);
        rd = (s == ON);
        ft = (s == CD) || (s == LK);
        return {s, pe, rd, ft, r};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_on = 1'b1; powered = 1'b1; current_ma = 12'd120;
        step(3);
        checks++;
        if (obs !== ex(OFF, 2'd0)) begin
            errors++; $display("FAIL reset_hold got %b exp %b", obs, ex(OFF, 2'd0));
        end
        rst = 1'b0;
        step(1);
        checks++;
        if (obs !== ex(SS, 2'd0)) begin
            errors++; $display("FAIL reset_release got %b exp %b", obs, ex(SS, 2'd0));
        end
    endtask

    task automatic test_power_up;
        step(15);
        checks++;
        if (obs !== ex(SS, 2'd0)) begin
            errors++; $display("FAIL ss_last_cycle got %b exp %b", obs, ex(SS, 2'd0));
        end
        step(1);
        checks++;
        if (obs !== ex(ON, 2'd0)) begin
            errors++; $display("FAIL ss_to_on got %b exp %b", obs, ex(ON, 2'd0));
        end
    endtask

    task automatic test_overcurrent;
        current_ma = 12'd500;
        step(12);
        checks++;
        if (obs !== ex(ON, 2'd0)) begin
            errors++; $display("FAIL oc_equal_limit got %b exp %b", obs, ex(ON, 2'd0));
        end
        current_ma = 12'd600;
        step(7);
        current_ma = 12'd120;
        step(1);
        checks++;
        if (obs !== ex(ON, 2'd0)) begin
            errors++; $display("FAIL oc_seven_then_clear got %b exp %b", obs, ex(ON, 2'd0));
        end
        current_ma = 12'd600;
        step(7);
        checks++;
        if (obs !== ex(ON, 2'd0)) begin
            errors++; $display("FAIL oc_seven got %b exp %b", obs, ex(ON, 2'd0));
        end
        step(1);
        checks++;
        if (obs !== ex(CD, 2'd0)) begin
            errors++; $display("FAIL oc_trip got %b exp %b", obs, ex(CD, 2'd0));
        end
    endtask

    task automatic test_retry;
`ifdef PWR_SEQ_AUTO_RETRY_EN
        for (int k = 1; k <= 3; k++) begin
            step(63);
            checks++;
            if (obs !== ex(CD, 2'(k - 1))) begin
                errors++; $display("FAIL retry%0d_cd_hold got %b exp %b", k, obs, ex(CD, 2'(k - 1)));
            end
            step(1);
            checks++;
            if (obs !== ex(SS, 2'(k))) begin
                errors++; $display("FAIL retry%0d_restart got %b exp %b", k, obs, ex(SS, 2'(k)));
            end
            step(24);
            checks++;
            if (obs !== ex(CD, 2'(k))) begin
                errors++; $display("FAIL retry%0d_retrip got %b exp %b", k, obs, ex(CD, 2'(k)));
            end
        end
        step(64);
        checks++;
        if (obs !== ex(LK, 2'd3)) begin
            errors++; $display("FAIL retry_lockout got %b exp %b", obs, ex(LK, 2'd3));
        end
`else
        step(63);
        checks++;
        if (obs !== ex(CD, 2'd0)) begin
            errors++; $display("FAIL cd_hold got %b exp %b", obs, ex(CD, 2'd0));
        end
        step(1);
        checks++;
        if (obs !== ex(LK, 2'd0)) begin
            errors++; $display("FAIL cd_lockout got %b exp %b", obs, ex(LK, 2'd0));
        end
`endif
    endtask

    task automatic test_lockout_exit;
        logic [1:0] r;
        r = retry_cnt === 2'd3 ? 2'd3 : 2'd0;
`ifdef PWR_SEQ_AUTO_RETRY_EN
        r = 2'd3;
`else
        r = 2'd0;
`endif
        req_on = 1'b0; fuse_blown = 1'b1;
        step(1);
        checks++;
        if (obs !== ex(LK, r)) begin
            errors++; $display("FAIL lock_fuse_held got %b exp %b", obs, ex(LK, r));
        end
        req_on = 1'b1; fuse_blown = 1'b0;
        step(1);
        checks++;
        if (obs !== ex(LK, r)) begin
            errors++; $display("FAIL lock_req_held got %b exp %b", obs, ex(LK, r));
        end
        req_on = 1'b0;
        step(1);
        checks++;
        if (obs !== ex(OFF, 2'd0)) begin
            errors++; $display("FAIL lock_exit got %b exp %b", obs, ex(OFF, 2'd0));
        end
    endtask

    task automatic test_fuse;
        req_on = 1'b1; current_ma = 12'd120; powered = 1'b1;
        step(17);
        checks++;
        if (obs !== ex(ON, 2'd0)) begin
            errors++; $display("FAIL fuse_pre_on got %b exp %b", obs, ex(ON, 2'd0));
        end
        fuse_blown = 1'b1;
        step(1);
        checks++;
        if (obs !== ex(LK, 2'd0)) begin
            errors++; $display("FAIL fuse_lockout got %b exp %b", obs, ex(LK, 2'd0));
        end
        fuse_blown = 1'b0; req_on = 1'b0;
        step(1);
        checks++;
        if (obs !== ex(OFF, 2'd0)) begin
            errors++; $display("FAIL fuse_release got %b exp %b", obs, ex(OFF, 2'd0));
        end
    endtask

    task automatic test_inrush;
        req_on = 1'b1; current_ma = 12'd1000;
        step(4);
        checks++;
        if (obs !== ex(SS, 2'd0)) begin
            errors++; $display("FAIL inrush_at_limit got %b exp %b", obs, ex(SS, 2'd0));
        end
        current_ma = 12'd1001;
        step(1);
        checks++;
        if (obs !== ex(CD, 2'd0)) begin
            errors++; $display("FAIL inrush_trip got %b exp %b", obs, ex(CD, 2'd0));
        end
        req_on = 1'b0; current_ma = 12'd120;
        step(1);
        checks++;
        if (obs !== ex(OFF, 2'd0)) begin
            errors++; $display("FAIL cd_req_off got %b exp %b", obs, ex(OFF, 2'd0));
        end
    endtask

    task automatic test_powered;
        req_on = 1'b1; powered = 1'b0;
        step(16);
        checks++;
        if (obs !== ex(SS, 2'd0)) begin
            errors++; $display("FAIL unpowered_ss got %b exp %b", obs, ex(SS, 2'd0));
        end
        step(1);
        checks++;
        if (obs !== ex(CD, 2'd0)) begin
            errors++; $display("FAIL unpowered_cd got %b exp %b", obs, ex(CD, 2'd0));
        end
        req_on = 1'b0;
        step(1);
        req_on = 1'b1; powered = 1'b1;
        step(17);
        checks++;
        if (obs !== ex(ON, 2'd0)) begin
            errors++; $display("FAIL repower_on got %b exp %b", obs, ex(ON, 2'd0));
        end
        powered = 1'b0;
        step(1);
        checks++;
        if (obs !== ex(CD, 2'd0)) begin
            errors++; $display("FAIL power_loss got %b exp %b", obs, ex(CD, 2'd0));
        end
        powered = 1'b1; req_on = 1'b0;
        step(1);
        req_on = 1'b1;
        step(17);
        req_on = 1'b0;
        step(1);
        checks++;
        if (obs !== ex(OFF, 2'd0)) begin
            errors++; $display("FAIL on_req_off got %b exp %b", obs, ex(OFF, 2'd0));
        end
    endtask

    task automatic test_reset_mid;
        req_on = 1'b1; powered = 1'b1; current_ma = 12'd120;
        step(6);
        checks++;
        if (obs !== ex(SS, 2'd0)) begin
            errors++; $display("FAIL pre_reset_ss got %b exp %b", obs, ex(SS, 2'd0));
        end
        rst = 1'b1;
        step(1);
        checks++;
        if (obs !== ex(OFF, 2'd0)) begin
            errors++; $display("FAIL mid_reset got %b exp %b", obs, ex(OFF, 2'd0));
        end
        step(2);
        checks++;
        if (obs !== ex(OFF, 2'd0)) begin
            errors++; $display("FAIL reset_ignores_req got %b exp %b", obs, ex(OFF, 2'd0));
        end
        rst = 1'b0;
        step(16);
        checks++;
        if (obs !== ex(SS, 2'd0)) begin
            errors++; $display("FAIL post_reset_ss got %b exp %b", obs, ex(SS, 2'd0));
        end
        step(1);
        checks++;
        if (obs !== ex(ON, 2'd0)) begin
            errors++; $display("FAIL post_reset_on got %b exp %b", obs, ex(ON, 2'd0));
        end
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_overcurrent;
        test_retry;
        test_lockout_exit;
        test_fuse;
        test_inrush;
        test_powered;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
